nibble_serial_subtractor: RTL and testbench

Multi-cycle N-bit subtractor that computes a − b − bin one 4-bit group per clock. Each group uses borrow look-ahead, the subtract-side counterpart of the team's 4-bit carry look-ahead adder. It sits behind a valid/ready handshake, so wide datapaths can reuse one 4-bit look-ahead slice instead of a full-width combinational chain. Typical uses are the compare/difference stages of the ALU and checker blocks.

---
 rtl/nibble_serial_subtractor.sv | 176 +++++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
//==============================================================================
// Module   : nibble_serial_subtractor
// Brief    : Multi-cycle a - b - bin, one 4-bit borrow look-ahead group per
//            clock behind valid/ready handshakes. Defining NSS_ADD_MODE_EN
//            adds the op port (1 = a + b + bin through the same slice).
// Revision : 1.0 - initial release
//==============================================================================
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef NSS_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int              c_N    = WIDTH / 4;
    localparam int              c_KW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // subtrahend as fed to the slice (inverted when adding)
    logic             r_bsign;   // original b sign, needed for the overflow rule
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_in_ready;
`ifdef NSS_ADD_MODE_EN
    logic             r_add;
`endif

    logic [WIDTH-1:0] w_b_cap;
    logic             w_bin_cap;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_ga;
    logic [3:0]       w_gb;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_d;
    logic             w_bout;
    logic             w_ovf;

    // Operand conditioning at capture: adding is a - ~b - ~cin on the same slice.
    always_comb begin
        w_b_cap   = b;
        w_bin_cap = bin;
`ifdef NSS_ADD_MODE_EN
        if (op) begin
            w_b_cap   = ~b;
            w_bin_cap = ~bin;
        end
`endif
    end

    always_comb begin
        w_a_sh = r_a >> {r_k, 2'b00};
        w_b_sh = r_b >> {r_k, 2'b00};
        w_ga   = w_a_sh[3:0];
        w_gb   = w_b_sh[3:0];
        w_g    = ~w_ga & w_gb;
        w_p    = ~(w_ga ^ w_gb);

        w_c[0] = r_br;
        w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        w_d    = w_ga ^ w_gb ^ w_c[3:0];

        // Only meaningful on the last group, where w_d[3] is the result sign.
        w_bout = w_c[4];
        w_ovf  = (r_a[WIDTH-1] != r_bsign) & (w_d[3] != r_a[WIDTH-1]);
`ifdef NSS_ADD_MODE_EN
        if (r_add) begin
            w_bout = ~w_c[4];
            w_ovf  = (r_a[WIDTH-1] == r_bsign) & (w_d[3] != r_a[WIDTH-1]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_bsign     <= 1'b0;
            r_br        <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef NSS_ADD_MODE_EN
            r_add       <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= w_b_cap;
                        r_bsign    <= b[WIDTH-1];
                        r_br       <= w_bin_cap;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_CALC;
`ifdef NSS_ADD_MODE_EN
                        r_add      <= op;
`endif
                    end
                end
                c_CALC: begin
                    r_diff[{r_k, 2'b00} +: 4] <= w_d;
                    r_br                      <= w_c[4];
                    if (r_k == c_LAST) begin
                        r_k         <= '0;
                        r_bout      <= w_bout;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_k         <= '0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
//==============================================================================
// Module   : tb_nibble_serial_subtractor
// Brief    : Self-checking bench for nibble_serial_subtractor (WIDTH = 16).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef NSS_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Plain-integer reference: exact result, then reduce modulo 2^WIDTH.
    function automatic void ref_model(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                                      input logic ebin, input logic eop,
                                      output logic [WIDTH-1:0] ed, output logic eb_out,
                                      output logic eovf);
        longint ua, ub, sa, sb, r, sr, lim;
        ua  = longint'(ea);
        ub  = longint'(eb);
        lim = longint'(1) << WIDTH;
        sa  = ea[WIDTH-1] ? ua - lim : ua;
        sb  = eb[WIDTH-1] ? ub - lim : ub;
        if (eop) begin
            r      = ua + ub + longint'(ebin);
            sr     = sa + sb + longint'(ebin);
            eb_out = (r >= lim);
        end else begin
            r      = ua - ub - longint'(ebin);
            sr     = sa - sb - longint'(ebin);
            eb_out = (ua < ub + longint'(ebin));
        end
        ed   = r[WIDTH-1:0];
        eovf = (sr < -(lim / 2)) || (sr > (lim / 2) - 1);
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tbin, input logic top);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta; b = tb; bin = tbin; op = top;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; bin = 1'b0; op = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== '0) begin n_err++; $display("FAIL reset_diff: got %h want 0000", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b want 0", bout); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        repeat (N + 3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_beats_in_valid: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h00FF, 16'h7FFF};
        logic [WIDTH-1:0] vb [5] = '{16'h0234, 16'h0001, 16'h0001, 16'h000F, 16'hFFFF};
        logic             vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [WIDTH-1:0] vd [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h00F0, 16'h8000};
        logic             vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic             vov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vc[i], 1'b0);
            wait_valid(lat);
            n_cmp++; if (lat != N) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, N); end
            n_cmp++; if ({diff, bout, ovf} !== {vd[i], vbo[i], vov[i]}) begin
                n_err++; $display("FAIL dir%0d_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                                  i, diff, bout, ovf, vd[i], vbo[i], vov[i]);
            end
            finish_op();
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_retire: got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h0005, 16'h0005, 1'b1, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 16'hAAAA; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            n_cmp++; if ({out_valid, in_ready, diff, bout, ovf} !== {1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL hold%0d: got v=%b rdy=%b diff=%h bout=%b ovf=%b want v=1 rdy=0 diff=ffff bout=1 ovf=0",
                                  i, out_valid, in_ready, diff, bout, ovf);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, diff, bout} !== {1'b1, 16'hFFFF, 1'b1}) begin
            n_err++; $display("FAIL hold_end: got v=%b diff=%h bout=%b want 1/ffff/1", out_valid, diff, bout);
        end
        finish_op();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release: got in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic seen = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;           // first CALC edge done
        rst = 1'b1;
        @(posedge clk); #1;           // second CALC edge sees rst
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_state: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < N + 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got out_valid seen=%b want 0", seen); end
        start_op(16'h00FF, 16'h000F, 1'b0, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat != N || diff !== 16'h00F0 || bout !== 1'b0) begin
            n_err++; $display("FAIL midrst_next: got lat=%0d diff=%h bout=%b want %0d/00f0/0", lat, diff, bout, N);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ta, tb, ed;
        logic tbin, top, eb, eo;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom); tb = WIDTH'($urandom); tbin = 1'($urandom); top = 1'b0;
`ifdef NSS_ADD_MODE_EN
            top = 1'($urandom);
`endif
            ref_model(ta, tb, tbin, top, ed, eb, eo);
            start_op(ta, tb, tbin, top);
            lat = 0;
            while (!out_valid && lat < 40) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom); op = 1'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++; if (lat != N || {diff, bout, ovf} !== {ed, eb, eo}) begin
                n_err++; $display("FAIL rnd%0d: a=%h b=%h bin=%b op=%b got lat=%0d diff=%h bout=%b ovf=%b want lat=%0d diff=%h bout=%b ovf=%b",
                                  i, ta, tb, tbin, top, lat, diff, bout, ovf, N, ed, eb, eo);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] qd[$];
        logic qb[$], qo[$];
        logic [WIDTH-1:0] ed;
        logic eb, eo;
        int last_acc = -1;
        out_ready = 1'b1; in_valid = 1'b1; op = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        for (int cyc = 0; cyc < 60 + N + 2; cyc++) begin
            if (cyc >= 60) in_valid = 1'b0;
            if (out_valid) begin
                n_cmp++;
                if (qd.size() == 0) begin
                    n_err++; $display("FAIL b2b_unexpected: got result diff=%h want none", diff);
                end else begin
                    ed = qd.pop_front(); eb = qb.pop_front(); eo = qo.pop_front();
                    if ({diff, bout, ovf} !== {ed, eb, eo}) begin
                        n_err++; $display("FAIL b2b_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                                          diff, bout, ovf, ed, eb, eo);
                    end
                end
            end
            if (in_ready && in_valid) begin
                ref_model(a, b, bin, op, ed, eb, eo);
                qd.push_back(ed); qb.push_back(eb); qo.push_back(eo);
                if (last_acc >= 0) begin
                    n_cmp++; if (cyc - last_acc != N + 2) begin
                        n_err++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
            end else begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (qd.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d pending want 0", qd.size()); end
        out_ready = 1'b0;
    endtask

`ifdef NSS_ADD_MODE_EN
    task automatic test_add_mode();
        int lat;
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_valid(lat);
        n_cmp++; if ({diff, bout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL add_wrap: got diff=%h carry=%b ovf=%b want 0000/1/0", diff, bout, ovf);
        end
        finish_op();
        start_op(16'h7FFF, 16'h0000, 1'b1, 1'b1);
        wait_valid(lat);
        n_cmp++; if ({diff, bout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL add_ovf: got diff=%h carry=%b ovf=%b want 8000/0/1", diff, bout, ovf);
        end
        finish_op();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0; op = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
`ifdef NSS_ADD_MODE_EN
        test_add_mode();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
